tx_controller: RTL and testbench

Transmit-side control engine for the UART transmitter. It accepts a byte from the processor write strobe and latches the frame configuration. It decodes the two upper frame bits (data bit 7, parity, or stop) and drives the load/shift strobes of the downstream 11-bit transmit shift register at the selected baud rate. It reports ready/done status back to the processor interface.

---
 rtl/tx_controller_if.sv | 29 ++
 rtl/tx_controller.sv | 148 ++++++++++++++
 tb/tb_tx_controller.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/tx_controller_if.sv
// tx_controller_if: processor-side bus of the UART transmit controller.
// master: write strobe, byte and frame config in; strobes and status back.
//   write, data[7:0], eight, pen, ohel, baud[3:0]   master -> slave
//   load, shift, bit10, bit9, ldata[6:0], TxRdy, tx_done   slave -> master
interface tx_controller_if;
    logic       write;
    logic [7:0] data;
    logic       eight;
    logic       pen;
    logic       ohel;
    logic [3:0] baud;
    logic       load;
    logic       shift;
    logic       bit10;
    logic       bit9;
    logic [6:0] ldata;
    logic       TxRdy;
    logic       tx_done;

    modport master (
        output write, data, eight, pen, ohel, baud,
        input  load, shift, bit10, bit9, ldata, TxRdy, tx_done
    );

    modport slave (
        input  write, data, eight, pen, ohel, baud,
        output load, shift, bit10, bit9, ldata, TxRdy, tx_done
    );
endinterface

// File: rtl/tx_controller.sv
// tx_controller: UART transmit control FSM driving an 11-bit shift register.
// Ports: clk, rst (async active-low), bus (tx_controller_if.slave).
//   Accepts a byte on write while TxRdy, latches data/baud and the decoded
//   frame bits 10/9, then pulses load, 11 shifts at the bit time, tx_done.
// Param BIT_TIME_OVR: nonzero replaces the baud table (cycles per bit).
// Macro TX_PARITY_EN: enables parity decode; otherwise pen/ohel are ignored.
module tx_controller #(
    parameter int BIT_TIME_OVR = 0
) (
    input  logic            clk,
    input  logic            rst,
    tx_controller_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        DONE
    } state_t;

    state_t      st, st_nxt;
    logic [18:0] cnt, cnt_nxt;
    logic [18:0] lk_m1;
    logic [3:0]  bcnt, bcnt_nxt;
    logic        accept;
    logic        b10_d, b9_d;

    logic        load_q, shift_q, done_q, rdy_q;
    logic        b10_q, b9_q;
    logic [6:0]  ldata_q;

    function automatic logic [18:0] bit_time(input logic [3:0] b);
        if (BIT_TIME_OVR != 0) return 19'(BIT_TIME_OVR);
        unique case (b)
            4'd0:    return 19'd333333;
            4'd1:    return 19'd83333;
            4'd2:    return 19'd41667;
            4'd3:    return 19'd20833;
            4'd4:    return 19'd10417;
            4'd5:    return 19'd5208;
            4'd6:    return 19'd2604;
            4'd7:    return 19'd1736;
            4'd8:    return 19'd868;
            4'd9:    return 19'd434;
            4'd10:   return 19'd217;
            4'd11:   return 19'd109;
            default: return 19'd868;
        endcase
    endfunction

    assign accept = bus.write && (st == IDLE);

`ifdef TX_PARITY_EN
    logic p;

    always_comb begin
        p = ^(bus.eight ? bus.data : {1'b0, bus.data[6:0]}) ^ bus.ohel;
        unique case ({bus.eight, bus.pen})
            2'b00:   {b10_d, b9_d} = 2'b11;
            2'b01:   {b10_d, b9_d} = {1'b1, p};
            2'b10:   {b10_d, b9_d} = {1'b1, bus.data[7]};
            default: {b10_d, b9_d} = {p, bus.data[7]};
        endcase
    end
`else
    logic unused_cfg;

    assign unused_cfg = bus.pen ^ bus.ohel;
    assign b10_d      = 1'b1;
    assign b9_d       = bus.eight ? bus.data[7] : 1'b1;
`endif

    always_comb begin
        st_nxt   = st;
        cnt_nxt  = cnt;
        bcnt_nxt = bcnt;
        unique case (st)
            IDLE: if (accept) st_nxt = LOAD;
            LOAD: begin
                cnt_nxt  = '0;
                bcnt_nxt = '0;
                st_nxt   = SEND;
            end
            SEND: begin
                if (cnt == lk_m1) begin
                    cnt_nxt  = '0;
                    bcnt_nxt = bcnt + 4'd1;
                    if (bcnt == 4'd10) st_nxt = DONE;
                end else begin
                    cnt_nxt = cnt + 19'd1;
                end
            end
            default: st_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st   <= IDLE;
            cnt  <= '0;
            bcnt <= '0;
        end else begin
            st   <= st_nxt;
            cnt  <= cnt_nxt;
            bcnt <= bcnt_nxt;
        end
    end

    // Outputs are registered from next-state values so each strobe lines
    // up with the state/count it belongs to without a cycle of lag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_q  <= 1'b0;
            shift_q <= 1'b0;
            done_q  <= 1'b0;
            rdy_q   <= 1'b1;
        end else begin
            load_q  <= (st_nxt == LOAD);
            shift_q <= (st_nxt == SEND) && (cnt_nxt == lk_m1);
            done_q  <= (st_nxt == DONE);
            rdy_q   <= (st_nxt == IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ldata_q <= 7'h7F;
            b10_q   <= 1'b1;
            b9_q    <= 1'b1;
            lk_m1   <= '0;
        end else if (accept) begin
            ldata_q <= bus.data[6:0];
            b10_q   <= b10_d;
            b9_q    <= b9_d;
            lk_m1   <= bit_time(bus.baud) - 19'd1;
        end
    end

    assign bus.load    = load_q;
    assign bus.shift   = shift_q;
    assign bus.tx_done = done_q;
    assign bus.TxRdy   = rdy_q;
    assign bus.ldata   = ldata_q;
    assign bus.bit10   = b10_q;
    assign bus.bit9    = b9_q;

endmodule

// File: tb/tb_tx_controller.sv
// tb_tx_controller: directed bench for tx_controller.
// Two DUTs: bit-time override 4, and baud table (override 0).
module tb_tx_controller;

`ifdef TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    tx_controller_if b4 ();
    tx_controller_if b0 ();

    tx_controller #(.BIT_TIME_OVR(4)) u4 (.clk(clk), .rst(rst), .bus(b4.slave));
    tx_controller #(.BIT_TIME_OVR(0)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));

    logic       sel = 1'b0;
    logic       wr = 1'b0;
    logic [7:0] dat = 8'h00;
    logic       e = 1'b0, pn = 1'b0, oh = 1'b0;
    logic [3:0] bd = 4'd0;

    assign b4.write = wr && !sel;
    assign b0.write = wr && sel;
    assign b4.data  = dat;
    assign b0.data  = dat;
    assign b4.eight = e;
    assign b0.eight = e;
    assign b4.pen   = pn;
    assign b0.pen   = pn;
    assign b4.ohel  = oh;
    assign b0.ohel  = oh;
    assign b4.baud  = bd;
    assign b0.baud  = bd;

    logic       m_load, m_shift, m_done, m_rdy, m_b10, m_b9;
    logic [6:0] m_ld;
    assign m_load  = sel ? b0.load    : b4.load;
    assign m_shift = sel ? b0.shift   : b4.shift;
    assign m_done  = sel ? b0.tx_done : b4.tx_done;
    assign m_rdy   = sel ? b0.TxRdy   : b4.TxRdy;
    assign m_b10   = sel ? b0.bit10   : b4.bit10;
    assign m_b9    = sel ? b0.bit9    : b4.bit9;
    assign m_ld    = sel ? b0.ldata   : b4.ldata;

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        nchk++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".rdy"},   int'(m_rdy),   1);
        chk({tag, ".load"},  int'(m_load),  0);
        chk({tag, ".shift"}, int'(m_shift), 0);
        chk({tag, ".done"},  int'(m_done),  0);
        chk({tag, ".b10"},   int'(m_b10),   1);
        chk({tag, ".b9"},    int'(m_b9),    1);
        chk({tag, ".ldata"}, int'(m_ld),    'h7F);
    endtask

    // Called right after an edge (#1). c counts edges since the accept edge.
    task automatic send(
        input string      tag,
        input bit         s,
        input logic [7:0] d,
        input bit         ei, pi, oi,
        input logic [3:0] bi,
        input int         k,
        input int         eld, eb10, eb9,
        input bit         busy,
        input bit         kill
    );
        int c, ns, last, bad, both, extra, cdone, crdy, quiet;
        bit bsent;
        sel = s; dat = d; e = ei; pn = pi; oh = oi; bd = bi;
        #1;
        chk({tag, ".rdy_pre"}, int'(m_rdy), 1);
        wr = 1'b1;
        @(posedge clk); #1;
        wr = 1'b0;
        chk({tag, ".load"},  int'(m_load), 1);
        chk({tag, ".rdy0"},  int'(m_rdy),  0);
        chk({tag, ".ldata"}, int'(m_ld),   eld);
        chk({tag, ".b10"},   int'(m_b10),  eb10);
        chk({tag, ".b9"},    int'(m_b9),   eb9);
        c = 0; ns = 0; last = 0; bad = 0; both = 0; extra = 0;
        cdone = -1; crdy = -1; bsent = 1'b0;
        for (int i = 0; i < 11 * k + 10; i++) begin
            if (m_load && c > 0) extra++;
            if (m_load && m_shift) both++;
            if (m_shift) begin
                ns++;
                if (c - last != k) bad++;
                last = c;
            end
            if (m_done) cdone = c;
            if (m_rdy) begin
                crdy = c;
                break;
            end
            if (kill && ns == 5) begin
                rst = 1'b0;
                #1;
                chk_reset({tag, ".kill"});
                repeat (2) @(posedge clk);
                #1;
                chk({tag, ".kill_hold"}, int'(m_rdy), 1);
                rst = 1'b1;
                quiet = 0;
                repeat (3 * k) begin
                    @(posedge clk); #1;
                    if (m_shift || m_load || m_done || !m_rdy) quiet++;
                end
                chk({tag, ".no_resume"}, quiet, 0);
                chk({tag, ".kill_sp"}, bad, 0);
                return;
            end
            if (busy && ns == 3 && !bsent) begin
                dat = 8'h3C; wr = 1'b1; bsent = 1'b1;
            end else begin
                wr = 1'b0;
            end
            @(posedge clk); #1;
            c++;
        end
        wr = 1'b0;
        chk({tag, ".shifts"},  ns,    11);
        chk({tag, ".spacing"}, bad,   0);
        chk({tag, ".overlap"}, both,  0);
        chk({tag, ".reload"},  extra, 0);
        chk({tag, ".done_at"}, cdone, 11 * k + 1);
        chk({tag, ".rdy_at"},  crdy,  11 * k + 2);
        chk({tag, ".ldata_end"}, int'(m_ld), eld);
        chk({tag, ".b10_end"}, int'(m_b10), eb10);
    endtask

    initial begin
        rst = 1'b0; wr = 1'b1; dat = 8'hFF; e = 1'b1; pn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("rst4");
        sel = 1'b1;
        #1;
        chk_reset("rst0");
        sel = 1'b0;
        wr = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("idle_after_rst", int'(m_rdy), 1);

        // A5: four ones, even parity -> P=0; busy write of 3C is dropped.
        send("basic", 1'b0, 8'hA5, 1'b1, 1'b1, 1'b0, 4'd0, 4,
             'h25, PAR ? 0 : 1, 1, 1'b1, 1'b0);
        @(posedge clk); #1;

        // 41 in 7 bits: two ones, odd sense -> P=1; reset after 5th shift.
        send("odd7", 1'b0, 8'h41, 1'b0, 1'b1, 1'b1, 4'd0, 4,
             'h41, 1, 1, 1'b0, 1'b1);
        chk_reset("post_kill");

        // 03 in 7 bits even: P=0 lands in bit9.
        send("even7", 1'b0, 8'h03, 1'b0, 1'b1, 1'b0, 4'd0, 4,
             'h03, 1, PAR ? 0 : 1, 1'b0, 1'b0);
        @(posedge clk); #1;

        // 8 bits, no parity: bit9 = data[7] = 0.
        send("np8", 1'b0, 8'h7E, 1'b1, 1'b0, 1'b0, 4'd0, 4,
             'h7E, 1, 0, 1'b0, 1'b0);
        @(posedge clk); #1;

        send("baud11", 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 4'd11, 109,
             'h7F, 1, 1, 1'b0, 1'b0);
        @(posedge clk); #1;

        // 80 in 8 bits, odd: one one -> P=0 in bit10.
        send("baud14", 1'b1, 8'h80, 1'b1, 1'b1, 1'b1, 4'd14, 868,
             'h00, PAR ? 0 : 1, 1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
